// File: rtl/pkg_instr_dec.sv
// rtl/pkg_instr_dec.sv - shared instruction group, opcode and encoder definitions
// Purpose: one source of truth for group identifiers, g2 opcode values,
//          per-group prefixes/opcode widths and the encoder FSM state type.
// Ports:   none (package).
package pkg_instr_dec;

  // Group codes; 3'd0, 3'd6 and 3'd7 are not a group and are unencodable.
  typedef enum logic [2:0] {
    GRP_G1 = 3'd1,
    GRP_G2 = 3'd2,
    GRP_G3 = 3'd3,
    GRP_G4 = 3'd4,
    GRP_G5 = 3'd5
  } instr_group;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PUSH0 = 2'd1,
    PUSH1 = 2'd2,
    ERR   = 2'd3
  } enc_state_t;

  // Fixed prefix bits at the top of word0 for each group.
  localparam logic [0:0] G1_PREFIX = 1'b0;
  localparam logic [1:0] G2_PREFIX = 2'b10;
  localparam logic [3:0] G3_PREFIX = 4'b1100;
  localparam logic [3:0] G4_PREFIX = 4'b1101;
  localparam logic [5:0] G5_PREFIX = 6'b111000;

  // Opcode field width of each group.
  localparam int G1_OP_W = 3;
  localparam int G2_OP_W = 6;
  localparam int G3_OP_W = 2;
  localparam int G4_OP_W = 4;
  localparam int G5_OP_W = 3;

  // Group 2 opcodes.
  localparam logic [5:0] instr_g2_op_add   = 6'h00;
  localparam logic [5:0] instr_g2_op_sub   = 6'h01;
  localparam logic [5:0] instr_g2_op_cpy   = 6'h09;
  localparam logic [5:0] instr_g2_op_invp  = 6'h10;
  localparam logic [5:0] instr_g2_op_negp  = 6'h11;
  localparam logic [5:0] instr_g2_op_lslp  = 6'h12;
  localparam logic [5:0] instr_g2_op_lsrp  = 6'h13;
  localparam logic [5:0] instr_g2_op_asrp  = 6'h14;
  localparam logic [5:0] instr_g2_op_rolp  = 6'h15;
  localparam logic [5:0] instr_g2_op_rorp  = 6'h16;
  localparam logic [5:0] instr_g2_op_rolcp = 6'h17;
  localparam logic [5:0] instr_g2_op_rorcp = 6'h18;
  localparam logic [5:0] instr_g2_op_cpyp  = 6'h19;
  localparam logic [5:0] instr_g2_op_swp   = 6'h1A;
  localparam logic [5:0] instr_g2_op_call  = 6'h20;
  localparam logic [5:0] instr_g2_op_ldr   = 6'h21;
  localparam logic [5:0] instr_g2_op_str   = 6'h22;

  // g2 ops whose ra field names a register pair (encoded as pair*2).
  function automatic logic g2_ra_is_pair(input logic [5:0] op);
    return op inside {instr_g2_op_invp, instr_g2_op_negp, instr_g2_op_lslp,
                      instr_g2_op_lsrp, instr_g2_op_asrp, instr_g2_op_rolp,
                      instr_g2_op_rorp, instr_g2_op_rolcp, instr_g2_op_rorcp,
                      instr_g2_op_cpyp, instr_g2_op_swp, instr_g2_op_call};
  endfunction

  // g2 ops whose rb field names a register pair.
  function automatic logic g2_rb_is_pair(input logic [5:0] op);
    return op inside {instr_g2_op_cpyp, instr_g2_op_swp,
                      instr_g2_op_ldr, instr_g2_op_str};
  endfunction

endpackage

// File: rtl/instr_word_fifo.sv
// rtl/instr_word_fifo.sv - show-ahead synchronous word FIFO
// Purpose: small output queue; head entry is always visible on pop_data.
// Ports:   clk, reset (sync, active-high); push/push_data write side;
//          pop/pop_data read side; count, full, empty status.
module instr_word_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - builds 16-bit instruction words from decoded fields
// Purpose: accepts field requests, encodes word0 (plus imm16 for group 5)
//          and streams words out in accept order through a small FIFO.
// Ports:   clk, reset (sync, active-high);
//          req_valid/req_ready + req_group/opcode/ra/rb/rc/imm request side;
//          word_valid/word_ready + word_data/word_first output stream;
//          enc_err (1-cycle pulse on unencodable request), busy.
module instr_encoder
  import pkg_instr_dec::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  instr_group  req_group,
  input  logic [5:0]  req_opcode,
  input  logic [3:0]  req_ra,
  input  logic [3:0]  req_rb,
  input  logic [2:0]  req_rc,
  input  logic [15:0] req_imm,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [15:0] word_data,
  output logic        word_first,
  output logic        enc_err,
  output logic        busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] ROOM_LIMIT = (CNT_W+1)'(FIFO_DEPTH - 2);

  enc_state_t  state;
  enc_state_t  state_nxt;
  instr_group  grp_q;
  logic [5:0]  op_q;
  logic [3:0]  ra_q;
  logic [3:0]  rb_q;
  logic [2:0]  rc_q;
  logic [15:0] imm_q;

  logic        push_q;
  logic [16:0] push_data_q;
  logic        push_nxt;
  logic [16:0] push_data_nxt;

  logic [CNT_W-1:0] count;
  logic             fifo_full;
  logic             fifo_empty;
  logic [16:0]      fifo_head;
  logic [CNT_W:0]   used;
  logic             accept;
  logic             req_ok;

  function automatic logic op_fits(input logic [5:0] op, input int width);
    return (op >> width) == 6'd0;
  endfunction

  function automatic logic req_is_valid(input instr_group g, input logic [5:0] op,
                                        input logic [3:0] ra, input logic [3:0] rb);
    case (g)
      GRP_G1: return op_fits(op, G1_OP_W);
      GRP_G2: return !(g2_ra_is_pair(op) && ra[3]) && !(g2_rb_is_pair(op) && rb[3]);
      GRP_G3: return op_fits(op, G3_OP_W) && !rb[3];
      GRP_G4: return op_fits(op, G4_OP_W);
      GRP_G5: return op_fits(op, G5_OP_W) && !rb[3];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] encode_word0(input instr_group g, input logic [5:0] op,
                                               input logic [3:0] ra, input logic [3:0] rb,
                                               input logic [2:0] rc, input logic [7:0] imm8);
    logic [3:0] ra_e;
    logic [3:0] rb_e;
    ra_e = g2_ra_is_pair(op) ? {ra[2:0], 1'b0} : ra;
    rb_e = g2_rb_is_pair(op) ? {rb[2:0], 1'b0} : rb;
    case (g)
      GRP_G1: return {G1_PREFIX, op[2:0], ra, imm8};
      GRP_G2: return {G2_PREFIX, op, ra_e, rb_e};
      GRP_G3: return {G3_PREFIX, op[1:0], ra, rb[2:0], rc};
      GRP_G4: return {G4_PREFIX, op[3:0], imm8};
      GRP_G5: return {G5_PREFIX, op[2:0], ra, rb[2:0]};
      default: return 16'h0000;
    endcase
  endfunction

  // A staged push is already committed to the FIFO, so it counts as used.
  // Two free slots guarantee a group 5 pair fits without splitting.
  assign used      = {1'b0, count} + {{CNT_W{1'b0}}, push_q};
  assign req_ready = ~reset && (state == IDLE) && (used <= ROOM_LIMIT);
  assign accept    = req_valid & req_ready;
  assign req_ok    = req_is_valid(req_group, req_opcode, req_ra, req_rb);

  assign word_valid = ~fifo_empty;
  assign word_first = fifo_head[16];
  assign word_data  = fifo_head[15:0];
  assign busy       = (state != IDLE) | ~fifo_empty | push_q;

  always_comb begin
    state_nxt     = state;
    push_nxt      = 1'b0;
    push_data_nxt = '0;
    enc_err       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = req_ok ? PUSH0 : ERR;
        end
      end
      PUSH0: begin
        push_nxt      = 1'b1;
        push_data_nxt = {1'b1, encode_word0(grp_q, op_q, ra_q, rb_q, rc_q, imm_q[7:0])};
        state_nxt     = (grp_q == GRP_G5) ? PUSH1 : IDLE;
      end
      PUSH1: begin
        push_nxt      = 1'b1;
        push_data_nxt = {1'b0, imm_q};
        state_nxt     = IDLE;
      end
      ERR: begin
        enc_err   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      push_q      <= 1'b0;
      push_data_q <= '0;
      grp_q       <= GRP_G1;
      op_q        <= '0;
      ra_q        <= '0;
      rb_q        <= '0;
      rc_q        <= '0;
      imm_q       <= '0;
    end else begin
      state       <= state_nxt;
      push_q      <= push_nxt;
      push_data_q <= push_data_nxt;
      if (accept) begin
        grp_q <= req_group;
        op_q  <= req_opcode;
        ra_q  <= req_ra;
        rb_q  <= req_rb;
        rc_q  <= req_rc;
        imm_q <= req_imm;
      end
    end
  end

  instr_word_fifo #(
    .WIDTH (17),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_q),
    .push_data (push_data_q),
    .pop       (word_ready),
    .pop_data  (fifo_head),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  logic unused_full;
  assign unused_full = fifo_full;

endmodule
